lsu_req_serializer: RTL and testbench



---
 rtl/lsu_req_serializer_if.sv | 58 +++++
 rtl/lsu_req_serializer.sv | 131 +++++++++++++
 tb/tb_lsu_req_serializer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/lsu_req_serializer_if.sv
// Bus bundle for lsu_req_serializer.
// Carries the warp-wide request channel (req_*) and the per-thread
// memory request channel (mem_req_*).
//   slave  : the serializer. It accepts req_* and drives mem_req_*.
//   master : the environment. It drives req_* and accepts mem_req_*.
interface lsu_req_serializer_if #(
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2,
  parameter int UUID_BITS   = 44,
  parameter int NR_BITS     = 5
);
  localparam int TID_W = $clog2(NUM_THREADS);

  logic                      req_valid;
  logic                      req_ready;
  logic [UUID_BITS-1:0]      req_uuid;
  logic [NW_BITS-1:0]        req_wid;
  logic [NUM_THREADS-1:0]    req_tmask;
  logic [3:0]                req_op_type;
  logic [NUM_THREADS*32-1:0] req_store_data;
  logic [NUM_THREADS*32-1:0] req_base_addr;
  logic [31:0]               req_offset;
  logic [NR_BITS-1:0]        req_rd;
  logic                      req_wb;

  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic                      mem_req_rw;
  logic [31:0]               mem_req_addr;
  logic [3:0]                mem_req_byteen;
  logic [31:0]               mem_req_data;
  logic [TID_W-1:0]          mem_req_tid;
  logic [UUID_BITS-1:0]      mem_req_uuid;
  logic [NW_BITS-1:0]        mem_req_wid;
  logic [NR_BITS-1:0]        mem_req_rd;
  logic                      mem_req_wb;
  logic                      mem_req_last;

  modport slave (
    input  req_valid, req_uuid, req_wid, req_tmask, req_op_type,
           req_store_data, req_base_addr, req_offset, req_rd, req_wb,
    output req_ready,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_byteen,
           mem_req_data, mem_req_tid, mem_req_uuid, mem_req_wid,
           mem_req_rd, mem_req_wb, mem_req_last,
    input  mem_req_ready
  );

  modport master (
    output req_valid, req_uuid, req_wid, req_tmask, req_op_type,
           req_store_data, req_base_addr, req_offset, req_rd, req_wb,
    input  req_ready,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_byteen,
           mem_req_data, mem_req_tid, mem_req_uuid, mem_req_wid,
           mem_req_rd, mem_req_wb, mem_req_last,
    output mem_req_ready
  );
endinterface

// File: rtl/lsu_req_serializer.sv
// lsu_req_serializer: breaks one warp-wide LSU request into per-thread
// memory requests. The active threads are issued one at a time, lowest
// thread index first.
// Ports:
//   clk   : sole clock
//   reset : asynchronous, active-low
//   bus   : lsu_req_serializer_if.slave (req_* in, mem_req_* out)
//   busy  : high while a warp is being issued
//
// state | meaning
// IDLE  | ready for a new warp request (req_ready = 1)
// ISSUE | presenting the lowest pending thread on mem_req_*
module lsu_req_serializer #(
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2,
  parameter int UUID_BITS   = 44,
  parameter int NR_BITS     = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  lsu_req_serializer_if.slave    bus,
  output logic                   busy
);
  localparam int TID_W = $clog2(NUM_THREADS);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [0:0]                   state_q, state_d;
  logic [NUM_THREADS-1:0]       pending_q, pending_d;
  logic [NUM_THREADS-1:0][31:0] addr_q;
  logic [NUM_THREADS-1:0][31:0] data_q;
  logic [UUID_BITS-1:0]         uuid_q;
  logic [NW_BITS-1:0]           wid_q;
  logic [NR_BITS-1:0]           rd_q;
  logic                         wb_q;
  logic [3:0]                   op_q;

  logic             accept;
  logic             issue;
  logic [TID_W-1:0] tid;
  logic             last;
  logic [31:0]      sel_addr;
  logic [1:0]       lane;
  logic [3:0]       byteen;

  assign accept = bus.req_valid && (state_q == IDLE);
  assign issue  = (state_q == ISSUE);

  // Lowest set bit wins: scan downwards so the last hit is the smallest index.
  always_comb begin
    tid = '0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (pending_q[i]) tid = TID_W'(i);
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest bit leaves nothing.
  assign last = (pending_q != '0) &&
                ((pending_q & (pending_q - NUM_THREADS'(1))) == '0);

  assign sel_addr = addr_q[tid];
  assign lane     = sel_addr[1:0];

  always_comb begin
    byteen = 4'b0000;
    case (op_q[1:0])
      2'd0:    byteen = 4'b0001 << lane;
      2'd1:    byteen = 4'b0011 << lane;
      default: byteen = 4'b1111;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    if (accept) begin
      if (bus.req_tmask != '0) begin
        pending_d = bus.req_tmask;
        state_d   = ISSUE;
      end
    end else if (issue && bus.mem_req_ready) begin
      pending_d      = pending_q;
      pending_d[tid] = 1'b0;
      if (last) state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      uuid_q    <= '0;
      wid_q     <= '0;
      rd_q      <= '0;
      wb_q      <= 1'b0;
      op_q      <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (accept && (bus.req_tmask != '0)) begin
        for (int i = 0; i < NUM_THREADS; i++) begin
          addr_q[i] <= bus.req_base_addr[i*32 +: 32] + bus.req_offset;
          data_q[i] <= bus.req_store_data[i*32 +: 32];
        end
        uuid_q <= bus.req_uuid;
        wid_q  <= bus.req_wid;
        rd_q   <= bus.req_rd;
        wb_q   <= bus.req_wb;
        op_q   <= bus.req_op_type;
      end
    end
  end

  assign bus.req_ready      = (state_q == IDLE);
  assign busy               = issue;
  assign bus.mem_req_valid  = issue;
  assign bus.mem_req_rw     = op_q[3];
  assign bus.mem_req_addr   = {sel_addr[31:2], 2'b00};
  // Gated so the reset/idle value is all-zero rather than the size-0 pattern.
  assign bus.mem_req_byteen = issue ? byteen : 4'b0000;
  assign bus.mem_req_data   = op_q[3] ? (data_q[tid] << {lane, 3'b000}) : 32'd0;
  assign bus.mem_req_tid    = tid;
  assign bus.mem_req_uuid   = uuid_q;
  assign bus.mem_req_wid    = wid_q;
  assign bus.mem_req_rd     = rd_q;
  assign bus.mem_req_wb     = wb_q;
  assign bus.mem_req_last   = last;
endmodule

// File: tb/tb_lsu_req_serializer.sv
module tb_lsu_req_serializer;
  localparam int NT = 4;

  logic clk;
  logic reset;
  logic busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] base_a [NT];
  logic [31:0] sd_a   [NT];
  logic [43:0] cur_uuid;
  logic [1:0]  cur_wid;
  logic [4:0]  cur_rd;
  logic        cur_wb;

  lsu_req_serializer_if #(.NUM_THREADS(NT), .NW_BITS(2), .UUID_BITS(44), .NR_BITS(5)) bus ();

  lsu_req_serializer #(.NUM_THREADS(NT), .NW_BITS(2), .UUID_BITS(44), .NR_BITS(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Presents a request at a negedge; it is accepted at the next posedge.
  // Returns at the following negedge with req_valid dropped.
  task automatic send(input logic [3:0] tmask, input logic [3:0] op, input logic [31:0] offset);
    cur_uuid = cur_uuid + 44'h1_0000_0001;
    cur_wid  = cur_wid + 2'd1;
    cur_rd   = cur_rd + 5'd3;
    cur_wb   = ~cur_wb;
    bus.req_valid   = 1'b1;
    bus.req_tmask   = tmask;
    bus.req_op_type = op;
    bus.req_offset  = offset;
    bus.req_uuid    = cur_uuid;
    bus.req_wid     = cur_wid;
    bus.req_rd      = cur_rd;
    bus.req_wb      = cur_wb;
    for (int i = 0; i < NT; i++) begin
      bus.req_base_addr[i*32 +: 32]  = base_a[i];
      bus.req_store_data[i*32 +: 32] = sd_a[i];
    end
    chk("req_ready_at_accept", {63'd0, bus.req_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Checks the presented thread at the current negedge, then moves on one cycle.
  task automatic expect_issue(input string tag, input int tid, input logic [31:0] addr,
                              input logic [3:0] be, input logic [31:0] data,
                              input logic rw, input logic last);
    chk({tag, "_valid"},  {63'd0, bus.mem_req_valid}, 64'd1);
    chk({tag, "_busy"},   {63'd0, busy}, 64'd1);
    chk({tag, "_rdy"},    {63'd0, bus.req_ready}, 64'd0);
    chk({tag, "_tid"},    {62'd0, bus.mem_req_tid}, 64'(tid));
    chk({tag, "_addr"},   {32'd0, bus.mem_req_addr}, {32'd0, addr});
    chk({tag, "_byteen"}, {60'd0, bus.mem_req_byteen}, {60'd0, be});
    chk({tag, "_data"},   {32'd0, bus.mem_req_data}, {32'd0, data});
    chk({tag, "_rw"},     {63'd0, bus.mem_req_rw}, {63'd0, rw});
    chk({tag, "_last"},   {63'd0, bus.mem_req_last}, {63'd0, last});
    chk({tag, "_uuid"},   {20'd0, bus.mem_req_uuid}, {20'd0, cur_uuid});
    chk({tag, "_wid"},    {62'd0, bus.mem_req_wid}, {62'd0, cur_wid});
    chk({tag, "_rd"},     {59'd0, bus.mem_req_rd}, {59'd0, cur_rd});
    chk({tag, "_wb"},     {63'd0, bus.mem_req_wb}, {63'd0, cur_wb});
    @(negedge clk);
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_valid"}, {63'd0, bus.mem_req_valid}, 64'd0);
    chk({tag, "_rdy"},   {63'd0, bus.req_ready}, 64'd1);
    chk({tag, "_busy"},  {63'd0, busy}, 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    cur_uuid = 44'h0_ABCD_0000; cur_wid = 2'd0; cur_rd = 5'd1; cur_wb = 1'b0;
    bus.req_valid = 1'b0; bus.req_tmask = '0; bus.req_op_type = '0;
    bus.req_offset = '0; bus.req_uuid = '0; bus.req_wid = '0;
    bus.req_rd = '0; bus.req_wb = 1'b0; bus.req_base_addr = '0;
    bus.req_store_data = '0; bus.mem_req_ready = 1'b1;
    for (int i = 0; i < NT; i++) begin base_a[i] = '0; sd_a[i] = '0; end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid",  {63'd0, bus.mem_req_valid}, 64'd0);
    chk("rst_last",   {63'd0, bus.mem_req_last}, 64'd0);
    chk("rst_busy",   {63'd0, busy}, 64'd0);
    chk("rst_byteen", {60'd0, bus.mem_req_byteen}, 64'd0);
    chk("rst_uuid",   {20'd0, bus.mem_req_uuid}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    expect_idle("post_rst");

    // LW, tmask 1011: tids 0,1,3
    for (int i = 0; i < NT; i++) base_a[i] = 32'h1000 + 32'(16 * i);
    send(4'b1011, 4'b0010, 32'd4);
    expect_issue("lw_t0", 0, 32'h1004, 4'b1111, 32'd0, 1'b0, 1'b0);
    expect_issue("lw_t1", 1, 32'h1014, 4'b1111, 32'd0, 1'b0, 1'b0);
    expect_issue("lw_t3", 3, 32'h1034, 4'b1111, 32'd0, 1'b0, 1'b1);
    expect_idle("lw_done");

    // SB, tmask 0100, addr 0x2003
    base_a[2] = 32'h2003; sd_a[2] = 32'h0000_00AB;
    send(4'b0100, 4'b1000, 32'd0);
    expect_issue("sb_t2", 2, 32'h2000, 4'b1000, 32'hAB00_0000, 1'b1, 1'b1);
    expect_idle("sb_done");

    // SH, tmask 0001, addr 0x3002
    base_a[0] = 32'h3002; sd_a[0] = 32'h0000_BEEF;
    send(4'b0001, 4'b1001, 32'd0);
    expect_issue("sh_t0", 0, 32'h3000, 4'b1100, 32'hBEEF_0000, 1'b1, 1'b1);
    expect_idle("sh_done");

    // Empty mask: consumed, nothing issued
    send(4'b0000, 4'b0010, 32'd0);
    expect_idle("empty0");
    @(negedge clk);
    expect_idle("empty1");

    // SW, tmask 1111 with a 5-cycle stall on tid 0
    for (int i = 0; i < NT; i++) begin
      base_a[i] = 32'h4000 + 32'(4 * i);
      sd_a[i]   = 32'h1111_1111 * 32'(i + 1);
    end
    bus.mem_req_ready = 1'b0;
    send(4'b1111, 4'b1010, 32'd0);
    for (int k = 0; k < 5; k++)
      expect_issue("stall_t0", 0, 32'h4000, 4'b1111, 32'h1111_1111, 1'b1, 1'b0);
    bus.mem_req_ready = 1'b1;
    expect_issue("sw_t0", 0, 32'h4000, 4'b1111, 32'h1111_1111, 1'b1, 1'b0);
    expect_issue("sw_t1", 1, 32'h4004, 4'b1111, 32'h2222_2222, 1'b1, 1'b0);
    expect_issue("sw_t2", 2, 32'h4008, 4'b1111, 32'h3333_3333, 1'b1, 1'b0);
    expect_issue("sw_t3", 3, 32'h400C, 4'b1111, 32'h4444_4444, 1'b1, 1'b1);
    expect_idle("sw_done");

    // Reset after two threads issued
    for (int i = 0; i < NT; i++) base_a[i] = 32'h5000 + 32'(16 * i);
    send(4'b1111, 4'b0010, 32'd0);
    expect_issue("mr_t0", 0, 32'h5000, 4'b1111, 32'd0, 1'b0, 1'b0);
    expect_issue("mr_t1", 1, 32'h5010, 4'b1111, 32'd0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk("mr_valid",  {63'd0, bus.mem_req_valid}, 64'd0);
    chk("mr_busy",   {63'd0, busy}, 64'd0);
    chk("mr_last",   {63'd0, bus.mem_req_last}, 64'd0);
    chk("mr_addr",   {32'd0, bus.mem_req_addr}, 64'd0);
    chk("mr_byteen", {60'd0, bus.mem_req_byteen}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    expect_idle("mr_release");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mr_no_resume", {63'd0, bus.mem_req_valid}, 64'd0);
    end

    // Address wrap
    base_a[0] = 32'hFFFF_FFF8;
    send(4'b0001, 4'b0010, 32'h10);
    expect_issue("wrap_t0", 0, 32'h0000_0008, 4'b1111, 32'd0, 1'b0, 1'b1);
    expect_idle("wrap_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: everything above is a fixed number of cycles.
  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
